// File: rtl/branch_predict_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and reset state.
// The GSHARE_EN macro selects global-history indexing in branch_predict.
package branch_predict_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    localparam logic [1:0] BP_RESET_STATE = BP_WNT;

    function automatic logic bp_predict(input logic [1:0] cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/branch_predict_if.sv
// Branch-outcome interface between the ID/EX pipeline and the predictor.
// The pipeline side is the master; the predictor is the slave.
interface branch_predict_if;

    logic [31:0] pcD;
    logic        branchD;
    logic        stallE;
    logic        flushE;
    logic        actual_takeE;
    logic        pred_takeD;
    logic        pred_takeE;
    logic        branchE;
    logic        mispredictE;

    modport master (
        output pcD, branchD, stallE, flushE, actual_takeE,
        input  pred_takeD, pred_takeE, branchE, mispredictE
    );

    modport slave (
        input  pcD, branchD, stallE, flushE, actual_takeE,
        output pred_takeD, pred_takeE, branchE, mispredictE
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Next-state logic for one 2-bit saturating branch counter.
module bp_sat_counter
    import branch_predict_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       taken_i,
    output logic [1:0] next_o
);

    always_comb begin
        next_o = cur_i;
        if (taken_i) begin
            if (cur_i != BP_ST) next_o = cur_i + 2'd1;
        end else begin
            if (cur_i != BP_SNT) next_o = cur_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict.sv
// 2-bit PHT branch predictor: ID lookup, ID/EX prediction register, EX training.
// Define GSHARE_EN to XOR a non-speculative global history into the PHT index.
module branch_predict
    import branch_predict_pkg::*;
#(
    parameter int unsigned PHT_AW  = 6,
    parameter int unsigned GHR_LEN = 6
) (
    input  logic      clk,
    input  logic      rst,
    branch_predict_if.slave bp
);

    localparam int unsigned PhtDepth = 1 << PHT_AW;

    logic [1:0]        pht_q [PhtDepth];
    logic [1:0]        pht_d [PhtDepth];
    logic [PHT_AW-1:0] idx_d;
    logic [PHT_AW-1:0] idx_e_q, idx_e_d;
    logic              pred_take_e_q, pred_take_e_d;
    logic              branch_e_q, branch_e_d;
    logic              upd_en;
    logic [1:0]        upd_cnt;
    logic [1:0]        lookup_cnt;
    logic              pred_take_d;

    logic unused_pc;
    assign unused_pc = ^{bp.pcD[31:PHT_AW+2], bp.pcD[1:0]};

    assign upd_en = branch_e_q & ~bp.stallE;

    bp_sat_counter u_sat_counter (
        .cur_i   (pht_q[idx_e_q]),
        .taken_i (bp.actual_takeE),
        .next_o  (upd_cnt)
    );

`ifdef GSHARE_EN
    logic [GHR_LEN-1:0] ghr_q, ghr_d;

    assign idx_d = bp.pcD[PHT_AW+1:2] ^ PHT_AW'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (upd_en) ghr_d = (ghr_q << 1) | GHR_LEN'(bp.actual_takeE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end
`else
    logic [31:0] unused_ghr_len;
    assign unused_ghr_len = GHR_LEN;

    assign idx_d = bp.pcD[PHT_AW+1:2];
`endif

    // Write-through bypass: a same-cycle update to the looked-up entry is visible in ID.
    always_comb begin
        lookup_cnt = pht_q[idx_d];
        if (upd_en && (idx_e_q == idx_d)) lookup_cnt = upd_cnt;
        pred_take_d = bp.branchD & bp_predict(lookup_cnt);
    end

    always_comb begin
        pht_d = pht_q;
        if (upd_en) pht_d[idx_e_q] = upd_cnt;
    end

    // Flush beats stall; the EX index is left alone on a flush since branchE is cleared.
    always_comb begin
        pred_take_e_d = pred_take_e_q;
        branch_e_d    = branch_e_q;
        idx_e_d       = idx_e_q;
        if (bp.flushE) begin
            pred_take_e_d = 1'b0;
            branch_e_d    = 1'b0;
        end else if (!bp.stallE) begin
            pred_take_e_d = pred_take_d;
            branch_e_d    = bp.branchD;
            idx_e_d       = idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PhtDepth; i++) pht_q[i] <= BP_RESET_STATE;
            pred_take_e_q <= 1'b0;
            branch_e_q    <= 1'b0;
            idx_e_q       <= '0;
        end else begin
            pht_q         <= pht_d;
            pred_take_e_q <= pred_take_e_d;
            branch_e_q    <= branch_e_d;
            idx_e_q       <= idx_e_d;
        end
    end

    assign bp.pred_takeD  = pred_take_d;
    assign bp.pred_takeE  = pred_take_e_q;
    assign bp.branchE     = branch_e_q;
    assign bp.mispredictE = branch_e_q & (bp.actual_takeE != pred_take_e_q);

endmodule

// File: tb/tb_branch_predict.sv
// Scoreboard bench for branch_predict; a behavioural PHT model supplies expected outputs.
module tb_branch_predict;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predict_if bp_if ();

    branch_predict #(
        .PHT_AW  (6),
        .GHR_LEN (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    typedef struct packed {
        logic pd;
        logic pe;
        logic be;
        logic me;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    int       m_pht [64];
    bit       m_pe, m_be;
    int       m_idx;
    bit [5:0] m_ghr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input bit [31:0] pc);
`ifdef GSHARE_EN
        return int'(pc[7:2] ^ m_ghr);
`else
        return int'(pc[7:2]);
`endif
    endfunction

    function automatic int sat(input int cnt, input bit taken);
        if (taken) return (cnt == 3) ? 3 : cnt + 1;
        return (cnt == 0) ? 0 : cnt - 1;
    endfunction

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check_eq({tag, "_pd"}, 32'(bp_if.pred_takeD),  32'(e.pd));
        check_eq({tag, "_pe"}, 32'(bp_if.pred_takeE),  32'(e.pe));
        check_eq({tag, "_be"}, 32'(bp_if.branchE),     32'(e.be));
        check_eq({tag, "_me"}, 32'(bp_if.mispredictE), 32'(e.me));
    endtask

    // Reset is asserted mid-cycle; any in-flight branch is dropped without training.
    task automatic do_reset(input string tag);
        exp_t e;
        rst = 1'b1;
        bp_if.pcD          = 32'h0000_0040;
        bp_if.branchD      = 1'b1;
        bp_if.stallE       = 1'b0;
        bp_if.flushE       = 1'b0;
        bp_if.actual_takeE = 1'b1;
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
        m_pe  = 1'b0;
        m_be  = 1'b0;
        m_idx = 0;
        m_ghr = '0;
        #1;
        e.pd = 1'b0;
        e.pe = 1'b0;
        e.be = 1'b0;
        e.me = 1'b0;
        sb_q.push_back(e);
        compare_outputs(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bp_if.branchD = 1'b0;
    endtask

    // Called at posedge+1: drive, predict, sample at negedge, then advance the model.
    task automatic step(input bit [31:0] pc, input bit br, input bit st, input bit fl,
                        input bit act, input string tag);
        exp_t e;
        int   id_idx, cnt_d, new_cnt;
        bit   upd;
        bp_if.pcD          = pc;
        bp_if.branchD      = br;
        bp_if.stallE       = st;
        bp_if.flushE       = fl;
        bp_if.actual_takeE = act;
        id_idx  = idx_of(pc);
        upd     = m_be && !st;
        new_cnt = sat(m_pht[m_idx], act);
        cnt_d   = (upd && (m_idx == id_idx)) ? new_cnt : m_pht[id_idx];
        e.pd = br && (cnt_d >= 2);
        e.pe = m_pe;
        e.be = m_be;
        e.me = m_be && (act != m_pe);
        sb_q.push_back(e);
        @(negedge clk);
        compare_outputs(tag);
        @(posedge clk);
        if (upd) begin
            m_pht[m_idx] = new_cnt;
            m_ghr = {m_ghr[4:0], act};
        end
        if (fl) begin
            m_pe = 1'b0;
            m_be = 1'b0;
        end else if (!st) begin
            m_pe  = e.pd;
            m_be  = br;
            m_idx = id_idx;
        end
        #1;
    endtask

    initial begin
        rst = 1'b0;
        bp_if.pcD          = '0;
        bp_if.branchD      = 1'b0;
        bp_if.stallE       = 1'b0;
        bp_if.flushE       = 1'b0;
        bp_if.actual_takeE = 1'b0;
        @(posedge clk);
        #1;
        do_reset("rst0");

        // First lookup is WNT; then repeated taken resolves with same-index bypass.
        step(32'h40, 1, 0, 0, 1, "t1_lookup");
        step(32'h40, 1, 0, 0, 1, "t2_tk1");
        step(32'h40, 1, 0, 0, 1, "t2_tk2");
        step(32'h40, 1, 0, 0, 0, "t2_nt");
        step(32'h40, 1, 0, 0, 0, "t2_after");
        step(32'h00, 0, 0, 0, 0, "t2_drain");

        // Stalled resolve must train exactly once, when the stall releases.
        do_reset("rst1");
        step(32'h40, 1, 0, 0, 0, "t3_issue");
        step(32'h00, 0, 1, 0, 1, "t3_st1");
        step(32'h00, 0, 1, 0, 1, "t3_st2");
        step(32'h00, 0, 1, 0, 1, "t3_st3");
        step(32'h00, 0, 0, 0, 1, "t3_go");
        step(32'h40, 1, 0, 0, 0, "t3_probe");
        step(32'h40, 1, 0, 0, 0, "t3_probe2");
        step(32'h40, 1, 0, 0, 0, "t3_probe3");

        // Flushed branch never reaches EX and never trains.
        step(32'h80, 1, 0, 1, 1, "t4_flush");
        step(32'h80, 1, 0, 0, 1, "t4_bubble");
        step(32'h80, 1, 0, 1, 1, "t4_flush_st");
        step(32'h80, 1, 1, 1, 0, "t4_fl_beats_st");
        step(32'h00, 0, 0, 0, 0, "t4_drain");

        // Mid-flight reset discards the EX branch.
        step(32'h40, 1, 0, 0, 1, "t5_inflight");
        do_reset("rst2");
        step(32'h40, 1, 0, 0, 1, "t5_post");

        // History-indexed sequence: T,T,N then a lookup at 0x40.
        step(32'h100, 1, 0, 0, 1, "t6_b0");
        step(32'h104, 1, 0, 0, 1, "t6_b1");
        step(32'h108, 1, 0, 0, 1, "t6_b2");
        step(32'h40,  1, 0, 0, 0, "t6_b3");
        step(32'h40,  1, 0, 0, 1, "t6_look");
        step(32'h40,  1, 0, 0, 1, "t6_look2");
        step(32'h58,  1, 0, 0, 1, "t6_other");
        step(32'h00,  0, 0, 0, 0, "t6_drain");

        for (int n = 0; n < 400; n++) begin
            bit [31:0] pc;
            pc = ($urandom & 32'hFFFF_FF03) | ((32'h10 + $urandom_range(0, 3)) << 2);
            step(pc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), "rand");
            if (n == 200) do_reset("rst_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
